// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: inserts load-use bubbles, flushes on taken branches,
// freezes the pipeline on data-memory busy, and keeps saturating stall/flush counters.
module hazard_ctrl #(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             ex_memRead,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             stall,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             dbg_state_o
);

  typedef enum logic {RUN = 1'b0, LU_WAIT = 1'b1} state_t;

  localparam logic [2:0] WCNT_INIT = 3'(LOAD_LAT - 1);

  state_t           state_q, state_d;
  logic [2:0]       wcnt_q, wcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             stall_inc, flush_inc;
  logic             hz;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign hz = ex_memRead && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    stall      = 1'b0;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    idex_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (rst) begin
      stall      = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_write = 1'b0;
    end else if (mem_busy) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_write = 1'b0;
    end else if (ex_branch_taken) begin
      // The flush squashes the ID instruction, so any pending bubble is dropped.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_d    = RUN;
      wcnt_d     = 3'd0;
      flush_inc  = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (hz) begin
            stall      = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            stall_inc  = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d = LU_WAIT;
              wcnt_d  = WCNT_INIT;
            end
          end
        end
        LU_WAIT: begin
          stall      = 1'b1;
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          stall_inc  = 1'b1;
          wcnt_d     = wcnt_q - 3'd1;
          if (wcnt_q == 3'd1) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_inc && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      wcnt_q      <= 3'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances (LOAD_LAT 1/2/3) share stimulus;
// the LOAD_LAT=2 instance uses 3-bit counters so saturation is reachable quickly.
module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       ex_memRead, ex_branch_taken, mem_busy;

  logic        s1, pw1, iw1, ew1, if1, ef1, st1;
  logic [15:0] sc1, fc1;
  logic        s2, pw2, iw2, ew2, if2, ef2, st2;
  logic [2:0]  sc2, fc2;
  logic        s3, pw3, iw3, ew3, if3, ef3, st3;
  logic [15:0] sc3, fc3;

  // Output vector order: {stall, pc_write, ifid_write, idex_write, ifid_flush, idex_flush}
  logic [5:0] o1, o2, o3;
  assign o1 = {s1, pw1, iw1, ew1, if1, ef1};
  assign o2 = {s2, pw2, iw2, ew2, if2, ef2};
  assign o3 = {s3, pw3, iw3, ew3, if3, ef3};

  localparam logic [5:0] O_RUN   = 6'b011100;
  localparam logic [5:0] O_BUBL  = 6'b100100;
  localparam logic [5:0] O_BUSY  = 6'b000000;
  localparam logic [5:0] O_FLUSH = 6'b011111;
  localparam logic [5:0] O_RST   = 6'b100000;

  int n_checks = 0;
  int n_pass   = 0;

  hazard_ctrl #(.LOAD_LAT(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_memRead(ex_memRead),
    .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .stall(s1), .pc_write(pw1), .ifid_write(iw1), .idex_write(ew1),
    .ifid_flush(if1), .idex_flush(ef1), .stall_cnt(sc1), .flush_cnt(fc1), .dbg_state_o(st1));

  hazard_ctrl #(.LOAD_LAT(2), .CNT_W(3)) u2 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_memRead(ex_memRead),
    .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .stall(s2), .pc_write(pw2), .ifid_write(iw2), .idex_write(ew2),
    .ifid_flush(if2), .idex_flush(ef2), .stall_cnt(sc2), .flush_cnt(fc2), .dbg_state_o(st2));

  hazard_ctrl #(.LOAD_LAT(3), .CNT_W(16)) u3 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_memRead(ex_memRead),
    .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .stall(s3), .pc_write(pw3), .ifid_write(iw3), .idex_write(ew3),
    .ifid_flush(if3), .idex_flush(ef3), .stall_cnt(sc3), .flush_cnt(fc3), .dbg_state_o(st3));

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] r1,
                       input logic [4:0] r2, input logic br, input logic busy);
    ex_memRead      = mr;
    ex_rd           = rd;
    id_rs1          = r1;
    id_rs2          = r2;
    ex_branch_taken = br;
    mem_busy        = busy;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    settle();
    check("rst_outs", {26'd0, o1}, {26'd0, O_RST});
    check("rst_stall_cnt", {16'd0, sc1}, 32'd0);
    check("rst_flush_cnt", {16'd0, fc1}, 32'd0);
    step();
    rst = 1'b0;
    settle();
    check("idle_run", {26'd0, o1}, {26'd0, O_RUN});

    // Load-use on rs1, LOAD_LAT=1
    drive(1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0);
    settle();
    check("ll1_bubble", {26'd0, o1}, {26'd0, O_BUBL});
    step();
    drive(1'b0, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0);
    settle();
    check("ll1_back_run", {26'd0, o1}, {26'd0, O_RUN});
    check("ll1_stall_cnt", {16'd0, sc1}, 32'd1);
    check("ll1_state", {31'd0, st1}, 32'd0);

    // Load-use on rs2, LOAD_LAT=3: three bubble cycles
    do_reset();
    drive(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0);
    settle();
    check("ll3_c1", {26'd0, o3}, {26'd0, O_BUBL});
    step();
    drive(1'b0, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0);
    settle();
    check("ll3_c2", {26'd0, o3}, {26'd0, O_BUBL});
    check("ll3_state_wait", {31'd0, st3}, 32'd1);
    step();
    settle();
    check("ll3_c3", {26'd0, o3}, {26'd0, O_BUBL});
    step();
    settle();
    check("ll3_run", {26'd0, o3}, {26'd0, O_RUN});
    check("ll3_stall_cnt", {16'd0, sc3}, 32'd3);

    // x0 destination and non-matching sources never stall
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    settle();
    check("x0_no_stall", {26'd0, o3}, {26'd0, O_RUN});
    step();
    drive(1'b1, 5'd7, 5'd3, 5'd4, 1'b0, 1'b0);
    settle();
    check("nomatch_no_stall", {26'd0, o3}, {26'd0, O_RUN});
    step();
    check("x0_stall_cnt", {16'd0, sc3}, 32'd0);

    // Branch taken coinciding with hz: flush wins, no bubble
    do_reset();
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    settle();
    check("br_hz_flush", {26'd0, o1}, {26'd0, O_FLUSH});
    step();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    settle();
    check("br_hz_flush_cnt", {16'd0, fc1}, 32'd1);
    check("br_hz_stall_cnt", {16'd0, sc1}, 32'd0);

    // Branch taken while in LU_WAIT (LOAD_LAT=3)
    do_reset();
    drive(1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b0);
    step();
    drive(1'b0, 5'd6, 5'd6, 5'd0, 1'b1, 1'b0);
    settle();
    check("br_wait_flush", {26'd0, o3}, {26'd0, O_FLUSH});
    step();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    settle();
    check("br_wait_run", {26'd0, o3}, {26'd0, O_RUN});
    check("br_wait_state", {31'd0, st3}, 32'd0);
    check("br_wait_cnts", {sc3, fc3}, {16'd1, 16'd1});

    // LOAD_LAT=2 with a 2-cycle mem_busy mid-stall: 4 frozen cycles, 2 bubbles
    do_reset();
    drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0);
    settle();
    check("busy_f1", {26'd0, o2}, {26'd0, O_BUBL});
    step();
    drive(1'b0, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1);
    settle();
    check("busy_f2", {26'd0, o2}, {26'd0, O_BUSY});
    step();
    settle();
    check("busy_f3", {26'd0, o2}, {26'd0, O_BUSY});
    check("busy_hold_state", {31'd0, st2}, 32'd1);
    check("busy_hold_cnt", {29'd0, sc2}, 32'd1);
    step();
    mem_busy = 1'b0;
    settle();
    check("busy_f4", {26'd0, o2}, {26'd0, O_BUBL});
    step();
    settle();
    check("busy_run", {26'd0, o2}, {26'd0, O_RUN});
    check("busy_stall_cnt", {29'd0, sc2}, 32'd2);

    // Asynchronous reset in LU_WAIT clears immediately
    do_reset();
    drive(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0);
    step();
    drive(1'b0, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0);
    settle();
    check("mid_stall", {26'd0, o3}, {26'd0, O_BUBL});
    rst = 1'b1;
    #1;
    check("async_rst_outs", {26'd0, o3}, {26'd0, O_RST});
    check("async_rst_state", {31'd0, st3}, 32'd0);
    check("async_rst_cnt", {16'd0, sc3}, 32'd0);
    rst = 1'b0;
    step();
    settle();
    check("post_rst_run", {26'd0, o3}, {26'd0, O_RUN});

    // Saturation on the 3-bit counters: continuous hazard, then continuous branches
    do_reset();
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step();
    check("sat_stall_cnt", {29'd0, sc2}, 32'd7);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step();
    check("sat_flush_cnt", {29'd0, fc2}, 32'd7);
    check("sat_stall_hold", {29'd0, sc2}, 32'd7);
    check("u1_flush_cnt_10", {16'd0, fc1}, 32'd10);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    check("sat_flush_stays", {29'd0, fc2}, 32'd7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage RISC-V core. It sits beside the decode stage and watches the register indices being read in ID and the load/branch status of the instruction in EX. It sequences load-use bubbles, branch-taken flushes and data-memory freezes by driving the `stall` input of the decode-stage control unit and the PC, IF/ID and ID/EX write/flush enables. It also keeps saturating stall and flush event counters for performance debug.

## Interface
- `LOAD_LAT`, 1: bubble cycles inserted per load-use hazard (legal 1..7).
- `CNT_W`, 16: width of each event counter.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `id_rs1`  in  5  source register 1 of the instruction in ID (inst[19:15]).
- `id_rs2`  in  5  source register 2 of the instruction in ID (inst[24:20]).
- `ex_memRead`  in  1  instruction in EX is a load.
- `ex_rd`  in  5  destination register of the instruction in EX.
- `ex_branch_taken`  in  1  branch in EX resolved taken this cycle.
- `mem_busy`  in  1  data memory not ready; the whole pipeline must hold.
- `stall`  out  1  to the control unit; zeroes all ID control outputs (bubble).
- `pc_write`  out  1  PC register load enable.
- `ifid_write`  out  1  IF/ID register load enable.
- `idex_write`  out  1  ID/EX register load enable.
- `ifid_flush`  out  1  clear IF/ID to NOP at the next edge.
- `idex_flush`  out  1  clear ID/EX to NOP at the next edge.
- `stall_cnt`  out  CNT_W  number of bubble cycles issued, saturating.
- `flush_cnt`  out  CNT_W  number of branch flush events, saturating.

## Operation
- Hazard term: `hz = ex_memRead && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2)`.
- FSM states: RUN, LU_WAIT. A down-counter `wcnt` of 3 bits is used in LU_WAIT.
- The conditions below are evaluated each cycle in this priority order (first match wins).
  1. rst: outputs `stall`=1, `pc_write`=`ifid_write`=`idex_write`=0, both flushes 0. State forced to RUN, `wcnt`=0, both counters 0.
  2. `mem_busy`: `pc_write`=`ifid_write`=`idex_write`=0, `stall`=0, flushes 0. State, `wcnt` and counters hold.
  3. `ex_branch_taken` (either state): `ifid_flush`=`idex_flush`=1, all write enables 1, `stall`=0. Next state RUN, `wcnt`=0, `flush_cnt`+1.
  4. RUN with `hz`: `stall`=1, `pc_write`=`ifid_write`=0, `idex_write`=1 (the bubble enters EX), `stall_cnt`+1. If LOAD_LAT>1, next state LU_WAIT with `wcnt`=LOAD_LAT-1; otherwise stay in RUN.
  5. LU_WAIT: same outputs as item 4, `stall_cnt`+1, `wcnt`-1. When `wcnt`==1, next state RUN. `hz` is ignored in this state.
  6. RUN otherwise: all write enables 1, `stall`=0, flushes 0.
- Register x0 never causes a hazard.
- Counters saturate at 2^CNT_W-1 and never wrap.

## Timing
- All enable, flush and `stall` outputs are combinational from the current state and inputs (Mealy); there is zero-cycle latency from `hz` to `stall`.
- The FSM, `wcnt` and counters update on the rising edge of `clk`. A counter reflects an event on the cycle after that event.
- A load-use hazard holds PC and IF/ID for exactly LOAD_LAT consecutive non-busy cycles. `mem_busy` cycles in the middle extend the total stall without consuming `wcnt`.
- A branch-taken event coinciding with `hz` or LU_WAIT: the flush wins, the wrong-path instruction in ID is squashed, and no bubble is counted.
- Reset asserted mid-stall clears immediately (asynchronously). On the first edge after deassertion the block is in RUN and behaves per item 6.

## Test plan
- Load-use on rs1, LOAD_LAT=1: `ex_memRead`=1, `ex_rd`=5, `id_rs1`=5 for one cycle -> `stall`=1, `pc_write`=0, `ifid_write`=0 for 1 cycle, then back to RUN; `stall_cnt`=1.
- LOAD_LAT=3, hazard on rs2 (`ex_rd`=7, `id_rs2`=7), then `ex_memRead`=0 -> `stall` high for 3 cycles, `stall_cnt`=3; same stimulus with `ex_rd`=0 -> no stall.
- `ex_branch_taken`=1 in the same cycle as `hz` -> both flushes 1, `stall`=0, `flush_cnt`=1, `stall_cnt` unchanged.
- LOAD_LAT=2 with `mem_busy` pulsed for 2 cycles in the middle of the stall -> all write enables 0 during busy, 4 frozen cycles in total, `stall_cnt`=2.
- Reset in LU_WAIT, and counter preload at 0xFFFF with another event -> immediate RUN with counters 0; a saturated counter stays at 0xFFFF.
